rvv_fifo_push_sched: RTL and testbench

Push-side scheduler for the multi-write-port RVV FIFO. Up to NREQ independent producers present one entry each per cycle over valid/ready. The block grants them round-robin, limited by the FIFO's free space, and packs the granted entries onto the FIFO write lanes push0..push(NPUSH-1), lowest lane first, through a registered output stage. It sits directly in front of the FIFO's push interface and is the only driver of it.

---
 rtl/rvv_fifo_pkg.sv | 21 ++
 rtl/rvv_rr_multigrant.sv | 44 ++++
 rtl/rvv_fifo_push_sched.sv | 92 +++++++++
 tb/tb_rvv_fifo_push_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_fifo_pkg.sv
// Shared constants and helpers for the RVV FIFO push-side logic.
package rvv_fifo_pkg;

    localparam int unsigned DefaultDwidth = 32;
    localparam int unsigned NumPushLanes  = 4;

    // Most restrictive flag wins when several are set.
    function automatic logic [2:0] flags_to_space(
        input logic full,
        input logic af,
        input logic af2,
        input logic af3
    );
        if (full) return 3'd0;
        if (af)   return 3'd1;
        if (af2)  return 3'd2;
        if (af3)  return 3'd3;
        return 3'(NumPushLanes);
    endfunction

endpackage

// File: rtl/rvv_rr_multigrant.sv
// Round-robin multi-grant arbiter: grants up to space valid requesters starting at rr_ptr,
// assigning consecutive lanes in scan order.
module rvv_rr_multigrant #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NPUSH = 4,
    parameter int unsigned PW    = $clog2(NREQ),
    parameter int unsigned LW    = $clog2(NPUSH),
    parameter int unsigned SW    = $clog2(NPUSH + 1)
) (
    input  logic [NREQ-1:0]          valid_i,
    input  logic [PW-1:0]            rr_ptr_i,
    input  logic [SW-1:0]            space_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0][LW-1:0]  lane_o,
    output logic [PW-1:0]            rr_next_o
);

    int unsigned    cnt;
    int unsigned    idx;
    int unsigned    last;
    logic [PW-1:0]  idx_b;

    always_comb begin
        grant_o = '0;
        lane_o  = '0;
        cnt     = 0;
        idx     = 0;
        last    = 0;
        idx_b   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            idx = 32'(rr_ptr_i) + j;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_b = PW'(idx);
            if (valid_i[idx_b] && (cnt < 32'(space_i))) begin
                grant_o[idx_b] = 1'b1;
                lane_o[idx_b]  = LW'(cnt);
                cnt            = cnt + 1;
                last           = idx;
            end
        end
        rr_next_o = (cnt != 0) ? PW'((last + 1) % NREQ) : rr_ptr_i;
    end

endmodule

// File: rtl/rvv_fifo_push_sched.sv
// Push-side scheduler: grants producers round-robin within FIFO free space and packs the
// accepted entries onto registered FIFO write lanes, lowest lane first.
module rvv_fifo_push_sched
    import rvv_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DefaultDwidth,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NPUSH  = NumPushLanes
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     halt,
    input  logic                     full,
    input  logic                     almost_full,
    input  logic                     almost_full2,
    input  logic                     almost_full3,
    output logic [NPUSH-1:0]         push,
    output logic [NPUSH*DWIDTH-1:0]  push_data,
    output logic [$clog2(NREQ)-1:0]  rr_ptr
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned LW = $clog2(NPUSH);
    localparam int unsigned SW = $clog2(NPUSH + 1);

    logic [NPUSH-1:0]          push_d, push_q;
    logic [NPUSH*DWIDTH-1:0]   push_data_d, push_data_q;
    logic [PW-1:0]             rr_ptr_d, rr_ptr_q;

    int unsigned               inflight;
    int unsigned               flag_space;
    int unsigned               avail;
    logic [SW-1:0]             space;
    logic [NREQ-1:0]           grant;
    logic [NREQ-1:0][LW-1:0]   lane;

    // Entries on the lanes now are not yet visible in the flags, so deduct them.
    always_comb begin
        inflight = 0;
        for (int k = 0; k < NPUSH; k++) inflight = inflight + 32'(push_q[k]);
        flag_space = 32'(flags_to_space(full, almost_full, almost_full2, almost_full3));
        if (flag_space > NPUSH) flag_space = NPUSH;
        avail = (flag_space > inflight) ? flag_space - inflight : 0;
        space = halt ? '0 : SW'(avail);
    end

    rvv_rr_multigrant #(
        .NREQ  (NREQ),
        .NPUSH (NPUSH)
    ) u_arb (
        .valid_i   (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .space_i   (space),
        .grant_o   (grant),
        .lane_o    (lane),
        .rr_next_o (rr_ptr_d)
    );

    assign req_ready = grant;

    // Unused lanes keep their old data; only the strobe drops.
    always_comb begin
        push_d      = '0;
        push_data_d = push_data_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                push_d[lane[i]] = 1'b1;
                push_data_d[lane[i]*DWIDTH +: DWIDTH] = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q      <= '0;
            push_data_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            push_q      <= push_d;
            push_data_q <= push_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign push      = push_q;
    assign push_data = push_data_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_rvv_fifo_push_sched.sv
// Randomized scoreboard bench for rvv_fifo_push_sched against a queue-based reference model.
module tb_rvv_fifo_push_sched;

    localparam int DW    = 32;
    localparam int NREQ  = 4;
    localparam int NPUSH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*DW-1:0]     req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   halt = 1'b0;
    logic                   full = 1'b0;
    logic                   almost_full = 1'b0;
    logic                   almost_full2 = 1'b0;
    logic                   almost_full3 = 1'b0;
    logic [NPUSH-1:0]       push;
    logic [NPUSH*DW-1:0]    push_data;
    logic [1:0]             rr_ptr;

    always #5 clk = ~clk;

    rvv_fifo_push_sched #(
        .DWIDTH (DW),
        .NREQ   (NREQ),
        .NPUSH  (NPUSH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .halt         (halt),
        .full         (full),
        .almost_full  (almost_full),
        .almost_full2 (almost_full2),
        .almost_full3 (almost_full3),
        .push         (push),
        .push_data    (push_data),
        .rr_ptr       (rr_ptr)
    );

    typedef struct {
        logic [NPUSH-1:0]    push;
        logic [NPUSH*DW-1:0] data;
        logic [1:0]          rr;
    } exp_t;

    exp_t           exp_q[$];
    int             n_cmp = 0;
    int             n_fail = 0;

    // Reference model state
    int             m_rr = 0;
    int             m_infl = 0;
    logic [DW-1:0]  m_lane[NPUSH];
    bit             pend[NREQ];
    logic [DW-1:0]  pdata[NREQ];
    int             seq[NREQ];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: present entries, compute the expected grant from the rules, queue the
    // expected lane contents for the monitor.
    task automatic step(input logic [3:0] fl, input logic h, input logic [NREQ-1:0] newreq);
        int fs, sp, n, last, idx;
        logic [NREQ-1:0] g;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && newreq[i]) begin
                pend[i]  = 1'b1;
                pdata[i] = {8'(i), 24'(seq[i])};
                seq[i]++;
            end
            req_valid[i]            = pend[i];
            req_data[i*DW +: DW]    = pdata[i];
        end
        {almost_full3, almost_full2, almost_full, full} = fl;
        halt = h;
        #1;
        if (fl[0])      fs = 0;
        else if (fl[1]) fs = 1;
        else if (fl[2]) fs = 2;
        else if (fl[3]) fs = 3;
        else            fs = NPUSH;
        sp = fs - m_infl;
        if (sp < 0) sp = 0;
        if (sp > NPUSH) sp = NPUSH;
        if (h) sp = 0;
        g = '0;
        n = 0;
        last = 0;
        e.push = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx = (m_rr + j) % NREQ;
            if (pend[idx] && n < sp) begin
                g[idx]    = 1'b1;
                e.push[n] = 1'b1;
                m_lane[n] = pdata[idx];
                n++;
                last      = idx;
                pend[idx] = 1'b0;
            end
        end
        check("req_ready", 128'(req_ready), 128'(g));
        if (n > 0) m_rr = (last + 1) % NREQ;
        m_infl = n;
        for (int k = 0; k < NPUSH; k++) e.data[k*DW +: DW] = m_lane[k];
        e.rr = 2'(m_rr);
        exp_q.push_back(e);
    endtask

    // Monitor: compares registered outputs one cycle after each issued step.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("push", 128'(push), 128'(e.push));
                check("push_data", 128'(push_data), 128'(e.data));
                check("rr_ptr", 128'(rr_ptr), 128'(e.rr));
            end
        end
    end

    initial begin
        logic [3:0] fl;
        int r;
        for (int k = 0; k < NPUSH; k++) m_lane[k] = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pdata[i] = '0;
            seq[i] = 0;
        end

        #2;
        check("reset_push", 128'(push), 128'(0));
        check("reset_data", 128'(push_data), 128'(0));
        check("reset_rr", 128'(rr_ptr), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // All four valid, empty FIFO
        step(4'b0000, 1'b0, 4'b1111);
        @(posedge clk); #2;
        check("first_push", 128'(push), 128'(4'b1111));
        check("first_data", 128'(push_data),
              {32'h03000000, 32'h02000000, 32'h01000000, 32'h00000000});
        check("first_rr", 128'(rr_ptr), 128'(0));

        // Steer rr_ptr to 2, then almost_full2 with all valid
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 1'b0, 4'b0011);
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0100, 1'b0, 4'b1111);
        @(posedge clk); #2;
        check("af2_push", 128'(push), 128'(4'b0011));
        check("af2_data", 128'(push_data),
              {32'h03000000, 32'h02000000, 32'h03000001, 32'h02000001});
        check("af2_rr", 128'(rr_ptr), 128'(0));

        // Asynchronous reset while lanes are busy
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("async_rst_push", 128'(push), 128'(0));
        check("async_rst_data", 128'(push_data), 128'(0));
        check("async_rst_rr", 128'(rr_ptr), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = 0;
        m_infl = 0;
        for (int k = 0; k < NPUSH; k++) m_lane[k] = '0;

        // Back-to-back: three grants, then inflight limits to one
        step(4'b0000, 1'b0, 4'b0111);
        step(4'b0000, 1'b0, 4'b1000);

        // Full for five cycles, then release
        repeat (5) step(4'b0001, 1'b0, 4'b1111);
        step(4'b0000, 1'b0, 4'b0000);

        // Two competing requesters with one slot per cycle
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0010, 1'b0, 4'b0010);
        repeat (6) step(4'b0100, 1'b0, 4'b1010);

        // Halt with valid present
        step(4'b0000, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);

        // Randomized traffic, including multi-flag patterns
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       fl = 4'(1 << r);
            else if (r == 4) fl = 4'($urandom_range(0, 15));
            else             fl = 4'b0000;
            step(fl, ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
        end

        repeat (3) step(4'b0000, 1'b0, 4'b0000);
        @(posedge clk); #3;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
